vga_text_render: RTL
====================

VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 SHALL have parameter FG_COLOR, default 12'hFFF, glyph foreground RGB444.
REQ-002 SHALL have parameter BG_COLOR, default 12'h000, background RGB444.
REQ-003 SHALL have parameter BLINK_BIT, default 5, frame-counter bit driving cursor blink.
REQ-004 SHALL have port clk  input  1  system clock (50 MHz); the block's only clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port p_tick  input  1  pixel-enable strobe from the sync generator.
REQ-007 SHALL have port video_on  input  1  high inside the 640x480 visible area.
REQ-008 SHALL have ports hsync_in, vsync_in  input  1 each  active-low syncs from the sync generator.
REQ-009 SHALL have ports x, y  input  10 each  current pixel column and row.
REQ-010 SHALL have port wr_en  input  1  text-buffer write strobe, sampled on clk.
REQ-011 SHALL have ports wr_col  input  7, wr_row  input  5, wr_char  input  8  write cell address and character code.
REQ-012 SHALL have ports cur_col  input  7, cur_row  input  5  cursor cell.
REQ-013 SHALL have ports hsync, vsync  output  1 each  syncs delayed to align with rgb.
REQ-014 SHALL have port rgb  output  12  RGB444 pixel colour.

Function
REQ-015 SHALL hold an 80x30 text buffer (2400 x 8 bit), address = row*80 + col.
REQ-016 SHALL perform a write on any clk edge with wr_en=1, independent of p_tick; writes with wr_col>=80 or wr_row>=30 SHALL be ignored.
REQ-017 SHALL read the buffer read-first: a same-cycle write and read of one cell returns the old character.
REQ-018 SHALL advance its 3-stage pipeline only on clk edges where p_tick=1; otherwise all pipeline registers hold.
REQ-019 Stage 1 SHALL read the character at col=x[9:3], row=y[8:4]. It SHALL register x[2:0], y[3:0], video_on, hsync_in and vsync_in.
REQ-020 Stage 2 SHALL read the font row at address {char, y[3:0]} (8 bits, MSB = leftmost pixel).
REQ-021 Stage 3 SHALL select bit 7-x[2:0]. It SHALL register rgb = bit ? FG_COLOR : BG_COLOR when delayed video_on=1, else 12'h000.
REQ-022 SHALL make hsync/vsync/rgb reflect the inputs sampled exactly 3 p_ticks earlier.
REQ-023 SHALL keep an 8-bit frame counter that increments once per falling edge of vsync_in, detected on p_tick, and wraps 255->0.
REQ-024 SHALL invert the glyph bit (swap FG/BG) for the cell at (cur_col, cur_row) while frame_cnt[BLINK_BIT]=1.
REQ-025 SHALL show no cursor when cur_col>=80 or cur_row>=30.
REQ-026 Pixels with x>=640 or y>=480 SHALL output 12'h000 regardless of buffer contents.

Reset
REQ-027 Reset SHALL asynchronously force rgb=12'h000, hsync=1, vsync=1, all delayed video_on bits=0 and frame_cnt=0.
REQ-028 Reset SHALL NOT alter text-buffer contents, which initialise to 8'h20 (space) at configuration.
REQ-029 Reset asserted mid-line SHALL take effect immediately. After release, the first valid rgb SHALL appear 3 p_ticks after the first p_tick.

Structure
REQ-030 Constants TEXT_COLS=80, TEXT_ROWS=30, FONT_W=8, FONT_H=16 and the RGB444 width SHALL live in a shared VGA package.
REQ-031 The font SHALL be a sub-module font_rom (12-bit address, 8-bit data, registered output, 256 glyphs x 16 rows).

Verification
REQ-032 Write 'A'(8'h41) to col 0 row 0; sweep x=0..7, y=0..15 -> after 3 p_ticks, rgb matches font_rom 'A' rows in FG_COLOR/BG_COLOR.
REQ-033 Toggle hsync_in low at x=656 for 96 pixels -> hsync falls exactly 3 p_ticks later and stays low for 96 p_ticks.
REQ-034 Write 8'h41 to col 80 row 5 -> buffer unchanged; reading col 0 row 6 returns its prior value.
REQ-035 Cursor at (2,1) with blank buffer, run 64 frames -> cell (x 16..23, y 16..31) is FG_COLOR for frames 32..63 and BG_COLOR for frames 0..31.
REQ-036 Write and read cell (5,5) in the same cycle, old 8'h20 and new 8'h42 -> that pixel shows blank; the next frame shows 'B'.
REQ-037 Assert reset at x=300 y=200 -> rgb=0, hsync=vsync=1 immediately; release -> the 4th p_tick carries valid pixel data.

Source files
------------

// File: rtl/vga_text_render_pkg.sv
// Shared VGA text-mode definitions: text grid / font geometry, colour width,
// pipeline stage records and the cell-address helper.
package vga_text_render_pkg;
  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int FONT_W    = 8;
  localparam int FONT_H    = 16;
  localparam int RGB_W     = 12;

  localparam int BUF_DEPTH = TEXT_COLS * TEXT_ROWS;
  localparam int H_VIS     = TEXT_COLS * FONT_W;   // 640
  localparam int V_VIS     = TEXT_ROWS * FONT_H;   // 480
  localparam int PX_W      = $clog2(FONT_W);
  localparam int PY_W      = $clog2(FONT_H);
  localparam int COL_W     = 7;
  localparam int ROW_W     = 5;
  localparam int ADDR_W    = 12;
  localparam logic [7:0] BLANK = 8'h20;

  // Stage-1 sideband: pixel position within the glyph plus delayed controls.
  typedef struct packed {
    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
    logic            vid;
    logic            hs;
    logic            vs;
    logic            cur;
  } s1_t;

  // Stage-2 sideband: the glyph row is already fetched, py is no longer needed.
  typedef struct packed {
    logic [PX_W-1:0] px;
    logic            vid;
    logic            hs;
    logic            vs;
    logic            cur;
  } s2_t;

  localparam s1_t S1_RST = '{px: '0, py: '0, vid: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0};
  localparam s2_t S2_RST = '{px: '0, vid: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0};

  // row*80 + col as shifts: row*64 + row*16 + col.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] row);
    return ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(col);
  endfunction

  function automatic logic cell_ok(input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
    return (int'(col) < TEXT_COLS) && (int'(row) < TEXT_ROWS);
  endfunction
endpackage

// File: rtl/vga_text_render_font_rom.sv
// font_rom: 256 glyphs x 16 rows of 8-pixel font data, MSB = leftmost pixel.
// Ports: clk, en (output register advances only when high), addr = {char, row},
// data = registered glyph row. Only 'A' and 'B' carry artwork; every other
// code, including space, renders blank.
module font_rom (
  input  logic        clk,
  input  logic        en,
  input  logic [11:0] addr,
  output logic [7:0]  data
);
  logic [7:0] rom_row;
  logic [7:0] data_d, data_q;

  always_comb begin
    rom_row = 8'h00;
    case (addr)
      12'h412: rom_row = 8'h10;  12'h413: rom_row = 8'h38;
      12'h414: rom_row = 8'h6C;  12'h415: rom_row = 8'hC6;
      12'h416: rom_row = 8'hC6;  12'h417: rom_row = 8'hFE;
      12'h418: rom_row = 8'hC6;  12'h419: rom_row = 8'hC6;
      12'h41A: rom_row = 8'hC6;  12'h41B: rom_row = 8'hC6;
      12'h422: rom_row = 8'hFC;  12'h423: rom_row = 8'h66;
      12'h424: rom_row = 8'h66;  12'h425: rom_row = 8'h66;
      12'h426: rom_row = 8'h7C;  12'h427: rom_row = 8'h66;
      12'h428: rom_row = 8'h66;  12'h429: rom_row = 8'h66;
      12'h42A: rom_row = 8'h66;  12'h42B: rom_row = 8'hFC;
      default: rom_row = 8'h00;
    endcase
    data_d = en ? rom_row : data_q;
  end

  always_ff @(posedge clk) data_q <= data_d;

  assign data = data_q;
endmodule

// File: rtl/vga_text_render.sv
// vga_text_render: 80x30 character renderer behind an external sync generator.
// Ports: clk/reset; p_tick pixel strobe; video_on, hsync_in, vsync_in, x, y
// from the sync generator; wr_en/wr_col/wr_row/wr_char text-buffer write;
// cur_col/cur_row blinking cursor cell; hsync, vsync, rgb delayed by the
// 3-stage pipeline (buffer read -> font read -> colour).
module vga_text_render
  import vga_text_render_pkg::*;
#(
  parameter logic [RGB_W-1:0] FG_COLOR  = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_COLOR  = 12'h000,
  parameter int               BLINK_BIT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_tick,
  input  logic             video_on,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [7:0]       wr_char,
  input  logic [COL_W-1:0] cur_col,
  input  logic [ROW_W-1:0] cur_row,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb
);
  // Cells are stored XOR BLANK so the power-up-zero RAM reads back as spaces;
  // reset never touches the buffer.
  logic [7:0] text_mem [BUF_DEPTH];

  logic              in_vis, cur_hit, wr_ok, vs_fall, glyph_bit;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        char_d, char_q, font_row;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic [RGB_W-1:0]  rgb_d, rgb_q;
  logic              hsync_d, hsync_q, vsync_d, vsync_q, vs_prev_d, vs_prev_q;
  logic [7:0]        frame_cnt_d, frame_cnt_q;

  always_comb begin
    in_vis  = (int'(x) < H_VIS) && (int'(y) < V_VIS);
    // Off-screen coordinates would address past the buffer; park them on cell 0.
    rd_addr = in_vis ? cell_addr(x[9:3], y[8:4]) : '0;
    cur_hit = cell_ok(cur_col, cur_row) && (x[9:3] == cur_col) &&
              (y[8:4] == cur_row) && frame_cnt_q[BLINK_BIT];
    wr_ok   = wr_en && cell_ok(wr_col, wr_row);
    vs_fall = vs_prev_q && !vsync_in;
    glyph_bit = font_row[3'd7 - s2_q.px] ^ s2_q.cur;

    char_d      = char_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    rgb_d       = rgb_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    vs_prev_d   = vs_prev_q;
    frame_cnt_d = frame_cnt_q;
    if (p_tick) begin
      char_d  = text_mem[rd_addr] ^ BLANK;
      s1_d    = '{px: x[PX_W-1:0], py: y[PY_W-1:0], vid: video_on && in_vis,
                  hs: hsync_in, vs: vsync_in, cur: cur_hit};
      s2_d    = '{px: s1_q.px, vid: s1_q.vid, hs: s1_q.hs, vs: s1_q.vs, cur: s1_q.cur};
      rgb_d   = s2_q.vid ? (glyph_bit ? FG_COLOR : BG_COLOR) : '0;
      hsync_d = s2_q.hs;
      vsync_d = s2_q.vs;
      vs_prev_d = vsync_in;
      if (vs_fall) frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Buffer port: writes on any edge, the read is registered and read-first.
  always_ff @(posedge clk) begin
    if (wr_ok) text_mem[cell_addr(wr_col, wr_row)] <= wr_char ^ BLANK;
    char_q <= char_d;
  end

  font_rom u_font (
    .clk  (clk),
    .en   (p_tick),
    .addr ({char_q, s1_q.py}),
    .data (font_row)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= S1_RST;
      s2_q        <= S2_RST;
      rgb_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      vs_prev_q   <= vs_prev_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rgb   = rgb_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
endmodule
